bus_rr_arbiter: RTL and testbench

Round-robin bus-ownership scheduler for the shared packet bus of `drvrs` devices. Each device raises a request when its FIFO holds a packet; the arbiter grants exactly one owner at a time, bounds ownership with a hold timeout, and inserts a one-cycle turnaround between owners. It also keeps per-device grant counters that the checker/scoreboard reads for fairness reports. It sits between the device request lines and the bus datapath's pop/push sequencing.

---
 rtl/bus_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
// Round-robin bus-ownership scheduler for a shared packet bus. Grants exactly
// one requester at a time, bounds each grant with a hold timeout, inserts a
// one-cycle turnaround between owners and keeps saturating per-device grant
// counters.
//
// Parameters
//   drvrs   : number of requesters (2..16)
//   timeout : maximum cycles one grant is held (2..255)
//   cnt_w   : width of each per-requester grant counter
//   id_w    : derived owner-index width
//
// Ports
//   clk      in   single rising-edge clock
//   reset    in   synchronous active-low reset
//   req      in   [drvrs]  per-device bus request
//   done     in   [drvrs]  per-device end-of-transfer pulse (owner only)
//   gnt      out  [drvrs]  one-hot grant, zero when no owner
//   gnt_vld  out           any grant active
//   gnt_id   out  [id_w]   current / last owner index
//   to_pulse out           one-cycle pulse on timeout revocation
//   to_id    out  [id_w]   owner revoked by the most recent timeout
//   gnt_cnt  out  [drvrs*cnt_w] grant counter i at [i*cnt_w +: cnt_w]
// -----------------------------------------------------------------------------
module bus_rr_arbiter #(
    parameter int drvrs   = 4,
    parameter int timeout = 16,
    parameter int cnt_w   = 16,
    parameter int id_w    = $clog2(drvrs)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [drvrs-1:0]       req,
    input  logic [drvrs-1:0]       done,
    output logic [drvrs-1:0]       gnt,
    output logic                   gnt_vld,
    output logic [id_w-1:0]        gnt_id,
    output logic                   to_pulse,
    output logic [id_w-1:0]        to_id,
    output logic [drvrs*cnt_w-1:0] gnt_cnt
);

    localparam int               hold_w   = $clog2(timeout);
    localparam logic [hold_w-1:0] hold_max = hold_w'(timeout - 1);
    localparam logic [cnt_w-1:0]  cnt_max  = {cnt_w{1'b1}};
    localparam logic [drvrs-1:0]  one_hot0 = {{(drvrs-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [id_w-1:0]               ptr_q, ptr_d;
    logic [hold_w-1:0]             hold_q, hold_d;
    logic [id_w-1:0]               owner_q, owner_d;
    logic [drvrs-1:0]              gnt_q, gnt_d;
    logic                          gnt_vld_q, gnt_vld_d;
    logic                          to_pulse_q, to_pulse_d;
    logic [id_w-1:0]               to_id_q, to_id_d;
    logic [drvrs-1:0][cnt_w-1:0]   cnt_q, cnt_d;
    logic [id_w-1:0]               win_s;

    // First requester after p, wrapping; p itself is scanned last. Walking the
    // offsets from far to near lets the nearest hit overwrite the result.
    function automatic logic [id_w-1:0] pick_winner(input logic [drvrs-1:0] r,
                                                    input logic [id_w-1:0]  p);
        logic [id_w-1:0] w;
        logic [id_w-1:0] ix;
        int              idx;
        w = p;
        for (int k = drvrs; k >= 1; k--) begin
            idx = (int'(p) + k) % drvrs;
            ix  = id_w'(idx);
            if (r[ix]) begin
                w = ix;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        to_pulse_d = 1'b0;
        to_id_d    = to_id_q;
        cnt_d      = cnt_q;
        win_s      = pick_winner(req, ptr_q);

        case (state_q)
            IDLE, RELEASE: begin
                if (|req) begin
                    state_d = GRANT;
                    owner_d = win_s;
                    gnt_d   = one_hot0 << win_s;
                    hold_d  = '0;
                    if (cnt_q[win_s] != cnt_max) begin
                        cnt_d[win_s] = cnt_q[win_s] + cnt_w'(1);
                    end else begin
                        cnt_d[win_s] = cnt_q[win_s];
                    end
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                // Normal release takes priority over a coincident timeout.
                if (done[owner_q] || !req[owner_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                end else if (hold_q == hold_max) begin
                    state_d    = RELEASE;
                    gnt_d      = '0;
                    ptr_d      = owner_q;
                    to_pulse_d = 1'b1;
                    to_id_d    = owner_q;
                end else begin
                    hold_d = hold_q + hold_w'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        gnt_vld_d = |gnt_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= id_w'(drvrs - 1);
            hold_q     <= '0;
            owner_q    <= '0;
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            to_pulse_q <= 1'b0;
            to_id_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            to_pulse_q <= to_pulse_d;
            to_id_q    <= to_id_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_vld  = gnt_vld_q;
    assign gnt_id   = owner_q;
    assign to_pulse = to_pulse_q;
    assign to_id    = to_id_q;
    assign gnt_cnt  = cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
// Directed steps followed by a randomized phase. Two arbiters share the same
// inputs: one with 16-bit counters, one with 2-bit counters for saturation.
// Expected values come from a transaction-level ownership model.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int CW  = 16;
    localparam int CWS = 2;
    localparam int IW  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    done;

    logic [N-1:0]    gnt_a, gnt_b;
    logic            gnt_vld_a, gnt_vld_b;
    logic [IW-1:0]   gnt_id_a, gnt_id_b;
    logic            to_pulse_a, to_pulse_b;
    logic [IW-1:0]   to_id_a, to_id_b;
    logic [N*CW-1:0] cnt_a;
    logic [N*CWS-1:0] cnt_b;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.drvrs(N), .timeout(TO), .cnt_w(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt_a), .gnt_vld(gnt_vld_a), .gnt_id(gnt_id_a),
        .to_pulse(to_pulse_a), .to_id(to_id_a), .gnt_cnt(cnt_a)
    );

    bus_rr_arbiter #(.drvrs(N), .timeout(TO), .cnt_w(CWS)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt_b), .gnt_vld(gnt_vld_b), .gnt_id(gnt_id_b),
        .to_pulse(to_pulse_b), .to_id(to_id_b), .gnt_cnt(cnt_b)
    );

    // Reference model: who owns the bus, who owned it last, how long held.
    int   m_owner;
    int   m_last;
    int   m_held;
    int   m_gnt_id;
    int   m_to_id;
    logic m_to_pulse;
    int   m_cnt [N];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (!reset) begin
            m_owner = -1; m_last = N - 1; m_held = 0;
            m_gnt_id = 0; m_to_id = 0; m_to_pulse = 1'b0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            m_to_pulse = 1'b0;
            if (m_owner >= 0) begin
                if (done[m_owner] || !req[m_owner]) begin
                    m_last = m_owner; m_owner = -1;
                end else if (m_held == TO) begin
                    m_last = m_owner; m_to_id = m_owner;
                    m_to_pulse = 1'b1; m_owner = -1;
                end else begin
                    m_held++;
                end
            end else begin
                w = winner(req, m_last);
                if (w >= 0) begin
                    m_owner = w; m_held = 1; m_gnt_id = w;
                    m_cnt[w]++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        int ca, cb;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("gnt", gnt_a, eg);
        chk("gnt_vld", gnt_vld_a, (m_owner >= 0) ? 1 : 0);
        chk("gnt_id", gnt_id_a, m_gnt_id);
        chk("to_pulse", to_pulse_a, m_to_pulse);
        chk("to_id", to_id_a, m_to_id);
        chk("gnt_sat", gnt_b, eg);
        for (int i = 0; i < N; i++) begin
            ca = (m_cnt[i] > 65535) ? 65535 : m_cnt[i];
            cb = (m_cnt[i] > 3) ? 3 : m_cnt[i];
            chk("gnt_cnt", cnt_a[i*CW +: CW], ca);
            chk("gnt_cnt_sat", cnt_b[i*CWS +: CWS], cb);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_grant(output int waited);
        waited = 0;
        while (m_owner < 0 && waited < 40) begin
            tick();
            waited++;
        end
        chk("grant_wait", gnt_vld_a, 1);
    endtask

    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    int w;
    int hi;

    initial begin
        reset = 1'b0; req = 4'b1111; done = 4'b0000;
        m_owner = -1; m_last = N - 1; m_held = 0; m_gnt_id = 0;
        m_to_id = 0; m_to_pulse = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Reset held with all requests high.
        repeat (5) tick();
        chk("rst_gnt", gnt_a, 4'b0000);
        chk("rst_cnt", cnt_a, 64'd0);

        // First edge out of reset grants device 0.
        reset = 1'b1;
        tick();
        chk("rst_first_gnt", gnt_a, 4'b0001);

        // Round-robin order with one idle cycle between owners.
        for (int g = 0; g < 6; g++) begin
            wait_grant(w);
            if (g > 0) chk("rr_gap", w, 1);
            chk("rr_order", gnt_id_a, exp_order[g]);
            if (g == 3) begin
                for (int i = 0; i < N; i++) chk("rr_cnt", cnt_a[i*CW +: CW], 1);
            end
            tick();
            done = 4'b0001 << exp_order[g];
            tick();
            done = 4'b0000;
        end
        req = 4'b0000;
        tick(); tick();

        // Timeout: grant lasts exactly TO cycles, then pulse, then re-grant.
        req = 4'b0100;
        wait_grant(w);
        hi = 1;
        while (gnt_a[2] && hi < 40) begin
            tick();
            if (gnt_a[2]) hi++;
        end
        chk("to_len", hi, TO);
        chk("to_pulse_hi", to_pulse_a, 1'b1);
        chk("to_id_val", to_id_a, 2);
        tick();
        chk("to_regrant", gnt_a, 4'b0100);
        chk("to_pulse_lo", to_pulse_a, 1'b0);

        // done on the final grant cycle beats the timeout.
        repeat (15) tick();
        done = 4'b0100;
        tick();
        chk("sim_gnt", gnt_a, 4'b0000);
        chk("sim_to_pulse", to_pulse_a, 1'b0);
        done = 4'b0000; req = 4'b0000;
        tick();

        // Non-owner noise leaves grant to device 1 alone; dropping req[1] releases.
        req = 4'b0010;
        wait_grant(w);
        req = 4'b0011; done = 4'b1100; tick();
        chk("noise1", gnt_a, 4'b0010);
        req = 4'b0010; done = 4'b0000; tick();
        chk("noise2", gnt_a, 4'b0010);
        req = 4'b0011; done = 4'b1000; tick();
        chk("noise3", gnt_a, 4'b0010);
        done = 4'b0000; req = 4'b0001; tick();
        chk("owner_drop", gnt_a, 4'b0000);

        // Mid-grant reset clears grant and counters.
        wait_grant(w);
        reset = 1'b0; tick();
        chk("midrst_gnt", gnt_a, 4'b0000);
        chk("midrst_cnt", cnt_a, 64'd0);
        reset = 1'b1;

        // Five grants to device 0: 2-bit counter sticks at 3.
        for (int g = 0; g < 5; g++) begin
            wait_grant(w);
            done = 4'b0001; tick(); done = 4'b0000;
        end
        chk("sat_cnt2", cnt_b[1:0], 2'd3);
        chk("sat_cnt16", cnt_a[15:0], 16'd5);

        // Randomized phase with sticky requests and sparse done/reset.
        req = 4'b0000;
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 149) != 0);
            req   = req ^ N'($urandom & $urandom & $urandom);
            done  = N'($urandom & $urandom & $urandom & $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
